// File: rtl/n_set_cache_replacement_controller_pkg.sv
// Shared definitions for the n-set cache replacement controller: policy
// encodings, controller state type and the CLOG2 width helper.
`ifndef N_SET_CACHE_REPLACEMENT_CONTROLLER_PKG_SV
`define N_SET_CACHE_REPLACEMENT_CONTROLLER_PKG_SV

`define CLOG2(x) $clog2(x)

package n_set_cache_replacement_controller_pkg;

    localparam int unsigned POLICY_LRU  = 0;
    localparam int unsigned POLICY_PLRU = 1;
    localparam int unsigned POLICY_FIFO = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } ctrl_state_e;

endpackage

`endif

// File: rtl/n_set_cache_replacement_controller_set_state.sv
// One cache set: valid bits, replacement-policy state and victim selection
// (lowest invalid way first, otherwise the policy victim).
module replacement_set_state
    import n_set_cache_replacement_controller_pkg::*;
#(
    parameter int unsigned SET_SIZE = 4,
    parameter int unsigned POLICY   = POLICY_LRU
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          flush,
    input  logic                          hit,
    input  logic [`CLOG2(SET_SIZE)-1:0]   hit_way,
    input  logic                          fill,
    input  logic [`CLOG2(SET_SIZE)-1:0]   fill_way,
    output logic [`CLOG2(SET_SIZE)-1:0]   victim
);

    localparam int unsigned BW_GRP = `CLOG2(SET_SIZE);

    logic [SET_SIZE-1:0] valid_q;
    logic                access;
    logic [BW_GRP-1:0]   access_way;
    logic [BW_GRP-1:0]   policy_victim;
    logic [BW_GRP-1:0]   free_way;
    logic                has_free;

    assign access     = hit | fill;
    assign access_way = fill ? fill_way : hit_way;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (fill) begin
            valid_q[fill_way] <= 1'b1;
        end
    end

    // Scan downwards so the lowest-index invalid way wins.
    always_comb begin
        has_free = 1'b0;
        free_way = '0;
        for (int unsigned i = SET_SIZE; i > 0; i--) begin
            if (!valid_q[i-1]) begin
                has_free = 1'b1;
                free_way = BW_GRP'(i - 1);
            end
        end
    end

    assign victim = has_free ? free_way : policy_victim;

    generate
        if (POLICY == POLICY_PLRU) begin : g_plru
            // Heap-ordered tree: level l starts at node 2^l-1; the way bits
            // above level l select the node within that level.
            logic [SET_SIZE-2:0] tree_q, tree_d;
            logic [BW_GRP-1:0]   upd_node, upd_prefix, upd_bits;
            logic [BW_GRP-1:0]   vic_node, vic_path;

            always_comb begin
                tree_d     = tree_q;
                upd_node   = '0;
                upd_prefix = '0;
                upd_bits   = '0;
                for (int unsigned l = 0; l < BW_GRP; l++) begin
                    upd_prefix       = access_way >> (BW_GRP - l);
                    upd_bits         = access_way >> (BW_GRP - 1 - l);
                    upd_node         = BW_GRP'((1 << l) - 1) + upd_prefix;
                    tree_d[upd_node] = ~upd_bits[0];
                end
            end

            always_comb begin
                vic_node = '0;
                vic_path = '0;
                for (int unsigned l = 0; l < BW_GRP; l++) begin
                    vic_node = BW_GRP'((1 << l) - 1) + vic_path;
                    vic_path = (vic_path << 1) | BW_GRP'(tree_q[vic_node]);
                end
            end

            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    tree_q <= '0;
                end else if (access) begin
                    tree_q <= tree_d;
                end
            end

            assign policy_victim = vic_path;
        end else if (POLICY == POLICY_FIFO) begin : g_fifo
            logic [BW_GRP-1:0] ptr_q;
            logic              unused_fifo;

            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    ptr_q <= '0;
                end else if (fill && fill_way == ptr_q) begin
                    ptr_q <= ptr_q + 1'b1;
                end
            end

            assign policy_victim = ptr_q;
            assign unused_fifo   = &{1'b0, access, access_way};
        end else begin : g_lru
            logic [BW_GRP-1:0] age_q [SET_SIZE];
            logic [BW_GRP-1:0] ref_age;
            logic [BW_GRP-1:0] oldest;

            assign ref_age = age_q[access_way];

            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    for (int unsigned i = 0; i < SET_SIZE; i++) begin
                        age_q[i] <= BW_GRP'(i);
                    end
                end else if (access) begin
                    for (int unsigned i = 0; i < SET_SIZE; i++) begin
                        if (BW_GRP'(i) == access_way) begin
                            age_q[i] <= '0;
                        end else if (age_q[i] < ref_age) begin
                            age_q[i] <= age_q[i] + 1'b1;
                        end
                    end
                end
            end

            always_comb begin
                oldest = '0;
                for (int unsigned i = 0; i < SET_SIZE; i++) begin
                    if (age_q[i] == BW_GRP'(SET_SIZE - 1)) begin
                        oldest = BW_GRP'(i);
                    end
                end
            end

            assign policy_victim = oldest;
        end
    endgenerate

endmodule

// File: rtl/n_set_cache_replacement_controller.sv
// Victim-selection controller: IDLE/SEARCH/DONE handshake over N_SET
// per-set replacement state instances.
module n_set_cache_replacement_controller
    import n_set_cache_replacement_controller_pkg::*;
#(
    parameter int unsigned CACHE_BLOCK_CAPACITY = 128,
    parameter int unsigned CACHE_SET_SIZE       = 4,
    parameter int unsigned POLICY               = POLICY_LRU
) (
    input  logic                                      clock_i,
    input  logic                                      resetn_i,
    input  logic                                      hit_i,
    input  logic                                      miss_i,
    input  logic                                      flush_i,
    input  logic [`CLOG2(CACHE_BLOCK_CAPACITY)-1:0]   addr_i,
    output logic                                      busy_o,
    output logic                                      done_o,
    output logic [`CLOG2(CACHE_BLOCK_CAPACITY)-1:0]   addr_o
);

    localparam int unsigned BW_CACHE_CAPACITY = `CLOG2(CACHE_BLOCK_CAPACITY);
    localparam int unsigned BW_GRP            = `CLOG2(CACHE_SET_SIZE);
    localparam int unsigned BW_SET            = BW_CACHE_CAPACITY - BW_GRP;
    localparam int unsigned N_SET             = 1 << BW_SET;
    localparam int unsigned BW_SET_IDX        = (BW_SET > 0) ? BW_SET : 1;

    ctrl_state_e                  state_q, state_d;
    logic [BW_SET_IDX-1:0]        set_sel, set_q;
    logic [BW_GRP-1:0]            addr_grp, fill_grp, victim_sel;
    logic [BW_GRP-1:0]            set_victim [N_SET];
    logic [BW_CACHE_CAPACITY-1:0] victim_addr;
    logic                         in_idle, do_hit, do_flush, do_fill;

    assign addr_grp = addr_i[BW_CACHE_CAPACITY-1 -: BW_GRP];
    assign fill_grp = addr_o[BW_CACHE_CAPACITY-1 -: BW_GRP];

    // Fully associative: no set field, addr_o carries the group only.
    generate
        if (BW_SET > 0) begin : g_sets
            assign set_sel     = addr_i[BW_SET_IDX-1:0];
            assign victim_addr = {victim_sel, set_q};
        end else begin : g_fa
            assign set_sel     = '0;
            assign victim_addr = victim_sel;
        end
    endgenerate

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (miss_i) begin
                    state_d = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                busy_o  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_idle  = (state_q == ST_IDLE);
    assign do_hit   = in_idle & hit_i & ~miss_i;
    assign do_flush = in_idle & flush_i & ~miss_i;
    assign do_fill  = (state_q == ST_DONE);

    // addr_o is captured whole so a new miss in IDLE cannot disturb it.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            set_q  <= '0;
            addr_o <= '0;
        end else begin
            if (in_idle && miss_i) begin
                set_q <= set_sel;
            end
            if (state_q == ST_SEARCH) begin
                addr_o <= victim_addr;
            end
        end
    end

    assign victim_sel = set_victim[set_q];

    for (genvar s = 0; s < N_SET; s++) begin : g_set
        replacement_set_state #(
            .SET_SIZE (CACHE_SET_SIZE),
            .POLICY   (POLICY)
        ) u_set_state (
            .clock    (clock_i),
            .resetn   (resetn_i),
            .flush    (do_flush),
            .hit      (do_hit && (set_sel == BW_SET_IDX'(s))),
            .hit_way  (addr_grp),
            .fill     (do_fill && (set_q == BW_SET_IDX'(s))),
            .fill_way (fill_grp),
            .victim   (set_victim[s])
        );
    end

endmodule

// File: tb/tb_n_set_cache_replacement_controller.sv
// Runs LRU, PLRU and FIFO instances on shared stimulus against a
// recency-list / tree / pointer model of each policy.
module tb_n_set_cache_replacement_controller;

    logic       clk = 1'b0;
    logic       rst_n, hit, miss, flush;
    logic [3:0] addr;
    logic [2:0] busy_w, done_w;
    logic [3:0] addr_w [3];

    int n_pass = 0;
    int n_chk  = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    for (genvar gp = 0; gp < 3; gp++) begin : g_dut
        n_set_cache_replacement_controller #(
            .CACHE_BLOCK_CAPACITY (16),
            .CACHE_SET_SIZE       (4),
            .POLICY               (gp)
        ) u_dut (
            .clock_i  (clk),
            .resetn_i (rst_n),
            .hit_i    (hit),
            .miss_i   (miss),
            .flush_i  (flush),
            .addr_i   (addr),
            .busy_o   (busy_w[gp]),
            .done_o   (done_w[gp]),
            .addr_o   (addr_w[gp])
        );
    end

    // Model: phase 0 idle, 1 search, 2 done.
    int phase, cap_set;
    bit valid [3][4][4];
    int lru_ord [4][4];   // per set, most recently used first
    bit plru [4][4];      // nodes 1..3, 1 = root, 0 = go left
    int fifo_ptr [4];
    int vg [3];
    int exp_addr [3];

    task automatic model_reset();
        phase = 0;
        cap_set = 0;
        for (int p = 0; p < 3; p++) begin
            exp_addr[p] = 0;
            vg[p] = 0;
            for (int s = 0; s < 4; s++)
                for (int w = 0; w < 4; w++) valid[p][s][w] = 1'b0;
        end
        for (int s = 0; s < 4; s++) begin
            fifo_ptr[s] = 0;
            for (int i = 0; i < 4; i++) begin
                lru_ord[s][i] = i;
                plru[s][i] = 1'b0;
            end
        end
    endtask

    task automatic model_access(input int p, input int s, input int w, input bit is_fill);
        int k;
        if (p == 0) begin
            k = 0;
            for (int i = 0; i < 4; i++) if (lru_ord[s][i] == w) k = i;
            for (int i = k; i > 0; i--) lru_ord[s][i] = lru_ord[s][i-1];
            lru_ord[s][0] = w;
        end else if (p == 1) begin
            plru[s][1] = !((w >> 1) & 1);
            plru[s][2 + ((w >> 1) & 1)] = !(w & 1);
        end else if (is_fill && w == fifo_ptr[s]) begin
            fifo_ptr[s] = (fifo_ptr[s] + 1) % 4;
        end
    endtask

    function automatic int model_victim(input int p, input int s);
        int d1;
        for (int w = 0; w < 4; w++) if (!valid[p][s][w]) return w;
        if (p == 0) return lru_ord[s][3];
        if (p == 1) begin
            d1 = int'(plru[s][1]);
            return d1 * 2 + int'(plru[s][2 + d1]);
        end
        return fifo_ptr[s];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            case (phase)
                0: begin
                    if (miss) begin
                        cap_set = int'(addr[1:0]);
                        phase = 1;
                    end else begin
                        if (hit)
                            for (int p = 0; p < 3; p++) model_access(p, int'(addr[1:0]), int'(addr[3:2]), 1'b0);
                        if (flush)
                            for (int p = 0; p < 3; p++)
                                for (int s = 0; s < 4; s++)
                                    for (int w = 0; w < 4; w++) valid[p][s][w] = 1'b0;
                    end
                end
                1: begin
                    for (int p = 0; p < 3; p++) begin
                        vg[p] = model_victim(p, cap_set);
                        exp_addr[p] = vg[p] * 4 + cap_set;
                    end
                    phase = 2;
                end
                default: begin
                    for (int p = 0; p < 3; p++) begin
                        valid[p][cap_set][vg[p]] = 1'b1;
                        model_access(p, cap_set, vg[p], 1'b1);
                    end
                    phase = 0;
                end
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int p = 0; p < 3; p++) begin
                chk($sformatf("busy_p%0d", p), 32'(busy_w[p]), 32'(phase != 0));
                chk($sformatf("done_p%0d", p), 32'(done_w[p]), 32'(phase == 2));
                chk($sformatf("addr_p%0d", p), 32'(addr_w[p]), 32'(exp_addr[p]));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic lit(input string name, input int p, input int val);
        chk($sformatf("model_%s_p%0d", name, p), 32'(exp_addr[p]), 32'(val));
        chk($sformatf("%s_p%0d", name, p), 32'(addr_w[p]), 32'(val));
    endtask

    task automatic do_miss(input int a, input bit with_hit);
        miss = 1'b1; hit = with_hit; addr = 4'(a);
        tick();
        miss = 1'($urandom % 2); hit = 1'($urandom % 2); addr = 4'($urandom);
        tick();
        chk("done_pulse", 32'(done_w), 32'h7);
        chk("busy_in_done", 32'(busy_w), 32'h7);
        miss = 1'b0; hit = 1'b0;
        tick();
    endtask

    task automatic do_hit(input int a);
        hit = 1'b1; addr = 4'(a);
        tick();
        hit = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; hit = 1'b0; miss = 1'b0; flush = 1'b0; addr = '0;
        model_reset();
        tick();
        tick();
        chk_en = 1'b1;
        tick();
        chk("reset_busy", 32'(busy_w), 32'h0);
        rst_n = 1'b1;

        // Fill set 1: invalid ways are taken in order.
        for (int g = 0; g < 4; g++) begin
            do_miss(g * 4 + 1, 1'b0);
            for (int p = 0; p < 3; p++) lit($sformatf("fill_set1_g%0d", g), p, g * 4 + 1);
        end

        // Set 0 full, hit way 1, then two misses.
        for (int g = 0; g < 4; g++) do_miss(g * 4, 1'b0);
        do_hit(4'h4);
        do_miss(0, 1'b0);
        lit("after_hit4_m1", 0, 4'h0);
        lit("after_hit4_m1", 1, 4'h8);
        lit("after_hit4_m1", 2, 4'h0);
        do_miss(0, 1'b0);
        lit("after_hit4_m2", 0, 4'h8);
        lit("after_hit4_m2", 1, 4'h0);
        lit("after_hit4_m2", 2, 4'h4);

        // Fresh state: set 0 full, hit way 0.
        do_reset();
        for (int g = 0; g < 4; g++) do_miss(g * 4, 1'b0);
        do_hit(4'h0);
        do_miss(0, 1'b0);
        lit("after_hit0", 0, 4'h4);
        lit("after_hit0", 1, 4'h8);
        lit("after_hit0", 2, 4'h0);

        // Hit with miss is dropped; flush frees set 2 again.
        do_miss(6, 1'b1);
        for (int p = 0; p < 3; p++) lit("hit_and_miss", p, 4'h2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        do_miss(6, 1'b0);
        for (int p = 0; p < 3; p++) lit("after_flush", p, 4'h2);

        // Reset during SEARCH aborts the miss.
        miss = 1'b1; addr = 4'h1;
        tick();
        miss = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("abort_busy", 32'(busy_w), 32'h0);
        chk("abort_done", 32'(done_w), 32'h0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("abort_no_done", 32'(done_w), 32'h0);
        do_miss(14, 1'b0);
        for (int p = 0; p < 3; p++) lit("after_abort", p, 4'h2);

        // Random traffic, every cycle checked by the compare process.
        for (int c = 0; c < 3000; c++) begin
            miss  = 1'(($urandom % 100) < 15);
            hit   = 1'(($urandom % 3) == 0);
            flush = 1'(($urandom % 40) == 0);
            addr  = 4'($urandom);
            rst_n = (($urandom % 400) == 0) ? 1'b0 : 1'b1;
            tick();
        end
        miss = 1'b0; hit = 1'b0; flush = 1'b0; rst_n = 1'b1;
        tick();
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/n_set_cache_replacement_controller.md
N_SET_CACHE_REPLACEMENT_CONTROLLER -- requirements
Module: n_set_cache_replacement_controller

Interface
REQ-001 SHALL have parameter CACHE_BLOCK_CAPACITY, default 128: total cache blocks, power of two.
REQ-002 SHALL have parameter CACHE_SET_SIZE, default 4: ways per set, power of two, 2..CACHE_BLOCK_CAPACITY.
REQ-003 SHALL have parameter POLICY, default 0: replacement mode; 0 true-LRU, 1 tree-PLRU, 2 FIFO.
REQ-004 SHALL have port clock_i, input, 1: the single clock, rising edge.
REQ-005 SHALL have port resetn_i, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port hit_i, input, 1: access to addr_i hit; updates policy state.
REQ-007 SHALL have port miss_i, input, 1: single-cycle request for a victim in the set of addr_i.
REQ-008 SHALL have port flush_i, input, 1: invalidate all ways of all sets.
REQ-009 SHALL have port addr_i, input, BW_CACHE_CAPACITY: cache block address {group, set}, where set = low BW_SET bits and group (way) = high BW_GRP bits.
REQ-010 SHALL have port busy_o, output, 1: high while a miss is in progress.
REQ-011 SHALL have port done_o, output, 1: single-cycle pulse; addr_o valid.
REQ-012 SHALL have port addr_o, output, BW_CACHE_CAPACITY: victim address {victim group, captured set}; for N_SET == 1 this is the victim group only.

Function
REQ-013 SHALL derive BW_GRP = clog2(CACHE_SET_SIZE), BW_SET = clog2(CACHE_BLOCK_CAPACITY) - BW_GRP, and N_SET = 2^BW_SET, and SHALL support N_SET == 1 (fully associative).
REQ-014 SHALL implement an FSM with states IDLE, SEARCH and DONE: IDLE moves to SEARCH on miss_i; SEARCH moves to DONE; DONE moves to IDLE.
REQ-015 SHALL capture the set index of addr_i in IDLE on the miss_i edge; later changes to addr_i SHALL NOT affect the result.
REQ-016 SHALL assert done_o only in DONE, so the pulse occurs 2 cycles after the miss_i sampling edge; busy_o SHALL be high in SEARCH and DONE.
REQ-017 SHALL register addr_o in SEARCH and hold it until the next SEARCH.
REQ-018 SHALL select the lowest-index invalid way of the set if one exists; otherwise it SHALL select the policy victim.
REQ-019 SHALL, at the DONE edge, mark the victim valid and apply a fill update to the set's policy state.
REQ-020 SHALL, on hit_i sampled in IDLE with miss_i low, apply a hit update to the set of addr_i for way = group of addr_i.
REQ-021 SHALL apply the following LRU rules: ages are BW_GRP bits; on a hit or fill to way w, every way with age < age(w) increments and w becomes 0; the victim is the way with age CACHE_SET_SIZE-1.
REQ-022 SHALL apply the following PLRU rules: CACHE_SET_SIZE-1 tree bits per set; an access sets the path bits to point away from w; the victim follows the bits from the root (0 = left).
REQ-023 SHALL apply the following FIFO rules: one BW_GRP-bit pointer per set, unchanged by hits; the victim is the pointer; a fill of the pointer's way increments it, wrapping from CACHE_SET_SIZE-1 to 0.
REQ-024 SHALL give miss_i priority when hit_i and miss_i are both high in IDLE; the hit SHALL be ignored.
REQ-025 SHALL ignore hit_i and miss_i in SEARCH and DONE.
REQ-026 SHALL, on flush_i in IDLE, clear all valid bits in one cycle while leaving policy state unchanged.
REQ-027 SHALL ignore flush_i outside IDLE, and miss_i SHALL take priority over a simultaneous flush_i.

Reset
REQ-028 SHALL, while resetn_i is low, immediately force: state IDLE, done_o 0, busy_o 0, addr_o 0, all valid bits 0, LRU age(way i) = i, PLRU bits 0, FIFO pointers 0.
REQ-029 SHALL abort an in-flight miss when reset is asserted mid-operation, with no done_o afterwards.

Structure
REQ-030 SHALL place the POLICY encodings and the CLOG2 macro in the shared cache package.
REQ-031 SHALL use one sub-module, replacement_set_state (per-set valid bits, policy state, victim computation), instantiated N_SET times in a generate loop; the top level SHALL hold the FSM and the set multiplexing.

Verification (CAPACITY=16, SET_SIZE=4 -> N_SET=4; addr = grp*4+set)
REQ-032 SHALL cover: reset, then 4 misses on set 1 -> done_o 2 cycles after each miss, addr_o = 0x1, 0x5, 0x9, 0xD.
REQ-033 SHALL cover: POLICY=0, fill set 0, hit 0x4, miss -> 0x0; next miss -> 0x8.
REQ-034 SHALL cover: POLICY=2, fill set 0, hit 0x4, miss -> 0x0; next miss -> 0x4.
REQ-035 SHALL cover: POLICY=1, fill set 0, hit 0x0, miss -> 0x8.
REQ-036 SHALL cover: hit_i and miss_i together on 0x6 -> victim 0x2 and no hit update; then flush_i and miss on 0x6 -> 0x2.
REQ-037 SHALL cover: resetn_i low during SEARCH -> no done_o and busy_o 0; after release, miss on set 2 -> 0x2.
